// File: rtl/edge_pulse_gen.sv
// edge_pulse_gen
// Multi-channel edge-to-pulse converter. Each channel synchronises an async
// input, detects rising/falling/both edges according to its mode, emits a
// stretched pulse and counts qualifying edges. A shared ARM phase after reset
// fills the synchronisers with live input values before detection is enabled,
// so an input that is already high at reset never produces a false edge.
module edge_pulse_gen #(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int PULSE_W     = 1,
  parameter int CNT_W       = 8,
  parameter int CNT_SAT     = 0
) (
  input  logic                clk_in,
  input  logic                rst,
  input  logic [CH-1:0]       sig_in,
  input  logic [2*CH-1:0]     mode,
  input  logic [CH-1:0]       cnt_clr,
  output logic [CH-1:0]       pulse_out,
  output logic                edge_any,
  output logic [CH*CNT_W-1:0] cnt_out,
  output logic [CH-1:0]       cnt_ovf
);

  localparam int ARM_W = $clog2(SYNC_STAGES + 2);
  localparam int STR_W = 8;
  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(SYNC_STAGES);
  localparam logic [STR_W-1:0] STR_LOAD = STR_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [0:0] {
    ST_ARM = 1'b0,
    ST_RUN = 1'b1
  } state_t;

  state_t                              state_r;
  state_t                              state_nxt_s;
  logic [ARM_W-1:0]                    arm_cnt_r;
  logic                                run_s;

  logic [SYNC_STAGES-1:0][CH-1:0]      sync_r;
  logic [CH-1:0]                       prev_r;
  logic [CH-1:0]                       sync_last_s;
  logic [CH-1:0]                       qualify_s;

  logic [CH-1:0][STR_W-1:0]            stretch_r;
  logic [CH-1:0][STR_W-1:0]            stretch_nxt_s;
  logic [CH-1:0]                       pulse_r;
  logic [CH-1:0]                       pulse_nxt_s;
  logic                                edge_any_r;

  logic [CH-1:0][CNT_W-1:0]            cnt_r;
  logic [CH-1:0][CNT_W-1:0]            cnt_nxt_s;
  logic [CH-1:0]                       ovf_r;
  logic [CH-1:0]                       ovf_nxt_s;

  assign pulse_out   = pulse_r;
  assign edge_any    = edge_any_r;
  assign cnt_out     = cnt_r;
  assign cnt_ovf     = ovf_r;
  assign sync_last_s = sync_r[SYNC_STAGES-1];

  // State register: ARM after every reset, RUN once the chains are primed.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_r <= ST_ARM;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: leave ARM on the (SYNC_STAGES+1)-th edge after reset.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_ARM: begin
        if (arm_cnt_r == ARM_LAST) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_ARM;
        end
      end
      ST_RUN:  state_nxt_s = ST_RUN;
      default: state_nxt_s = ST_ARM;
    endcase
  end

  // Output decode: edge detection is enabled only in RUN.
  always_comb begin
    run_s = 1'b0;
    case (state_r)
      ST_ARM:  run_s = 1'b0;
      ST_RUN:  run_s = 1'b1;
      default: run_s = 1'b0;
    endcase
  end

  // Arm counter: counts priming edges while in ARM, then freezes.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      arm_cnt_r <= {ARM_W{1'b0}};
    end else if ((state_r == ST_ARM) && (arm_cnt_r != ARM_LAST)) begin
      arm_cnt_r <= arm_cnt_r + ARM_W'(1);
    end else begin
      arm_cnt_r <= arm_cnt_r;
    end
  end

  // Synchroniser chains plus previous-value flop, loaded in ARM and RUN alike.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sync_r <= '0;
      prev_r <= {CH{1'b0}};
    end else begin
      if (SYNC_STAGES > 1) begin
        sync_r <= {sync_r[SYNC_STAGES-2:0], sig_in};
      end else begin
        sync_r <= sig_in;
      end
      prev_r <= sync_last_s;
    end
  end

  // Edge qualification against each channel's mode bits.
  always_comb begin
    qualify_s = {CH{1'b0}};
    for (int i = 0; i < CH; i++) begin
      qualify_s[i] = run_s &
                     (((sync_last_s[i] & ~prev_r[i]) & mode[2*i]) |
                      ((~sync_last_s[i] & prev_r[i]) & mode[2*i+1]));
    end
  end

  // Pulse stretcher: reload on every qualifying edge so merged pulses have no gap.
  always_comb begin
    stretch_nxt_s = stretch_r;
    pulse_nxt_s   = {CH{1'b0}};
    for (int i = 0; i < CH; i++) begin
      if (qualify_s[i]) begin
        stretch_nxt_s[i] = STR_LOAD;
        pulse_nxt_s[i]   = 1'b1;
      end else if (stretch_r[i] != {STR_W{1'b0}}) begin
        stretch_nxt_s[i] = stretch_r[i] - STR_W'(1);
        pulse_nxt_s[i]   = 1'b1;
      end else begin
        stretch_nxt_s[i] = {STR_W{1'b0}};
        pulse_nxt_s[i]   = 1'b0;
      end
    end
  end

  // Edge counters: clear wins over a same-cycle edge; wrap or saturate at max.
  always_comb begin
    cnt_nxt_s = cnt_r;
    ovf_nxt_s = ovf_r;
    for (int i = 0; i < CH; i++) begin
      if (cnt_clr[i]) begin
        cnt_nxt_s[i] = {CNT_W{1'b0}};
        ovf_nxt_s[i] = 1'b0;
      end else if (qualify_s[i]) begin
        if (cnt_r[i] == CNT_MAX) begin
          if (CNT_SAT != 0) begin
            cnt_nxt_s[i] = CNT_MAX;
          end else begin
            cnt_nxt_s[i] = {CNT_W{1'b0}};
          end
          ovf_nxt_s[i] = 1'b1;
        end else begin
          cnt_nxt_s[i] = cnt_r[i] + CNT_W'(1);
          ovf_nxt_s[i] = ovf_r[i];
        end
      end else begin
        cnt_nxt_s[i] = cnt_r[i];
        ovf_nxt_s[i] = ovf_r[i];
      end
    end
  end

  // Output and channel state registers.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      stretch_r  <= '0;
      pulse_r    <= {CH{1'b0}};
      edge_any_r <= 1'b0;
      cnt_r      <= '0;
      ovf_r      <= {CH{1'b0}};
    end else begin
      stretch_r  <= stretch_nxt_s;
      pulse_r    <= pulse_nxt_s;
      edge_any_r <= |pulse_nxt_s;
      cnt_r      <= cnt_nxt_s;
      ovf_r      <= ovf_nxt_s;
    end
  end

endmodule
